// File: rtl/case_lookup_arbiter.sv
// case_lookup_arbiter
//   Shares one 4-entry select-to-data lookup among four requesters.
//   - Grants one requester at a time.
//   - Latches that requester's 2-bit select code.
//   - Returns the looked-up value with a one-cycle response strobe.
//   - Flags select code 3, which the lookup table does not cover.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN - when defined, the lowest-index active requester wins.
//                           Otherwise arbitration is round-robin from ptr.
//
// Parameters:
//   DATA_W    response data width; table values are zero-extended (DATA_W >= 4)
//   PTR_INIT  round-robin pointer after reset (0..3)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[3:0]    level-sensitive requests
//   sel[7:0]    select codes; requester i uses sel[2i+1:2i]
//   lock[3:0]   requester i keeps the grant while lock[i] && req[i]
//   err_clr     clears err_sticky (a same-cycle set wins)
//   gnt[3:0]    one-hot grant, zero when idle
//   rsp_valid   one-cycle response strobe
//   rsp_id      requester owning the current response
//   rsp_data    lookup result
//   rsp_err     select code was uncovered; high together with rsp_valid
//   err_sticky  set by any rsp_err, held until err_clr
module case_lookup_arbiter #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned PTR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [7:0]        sel,
    input  logic [3:0]        lock,
    input  logic              err_clr,
    output logic [3:0]        gnt,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              err_sticky
);

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StGrant = 3'b010,
        StResp  = 3'b100
    } state_e;

    state_e     state_q;
    logic [1:0] sel_q;
    logic [1:0] win_q;
    logic [1:0] winner;
    logic [1:0] winner_sel;
    logic [1:0] held_sel;

    // Shared decode table. Code 3 is uncovered and returns zero.
    function automatic logic [3:0] lookup(input logic [1:0] code);
        logic [3:0] val;
        unique case (code)
            2'd0:    val = 4'hA;
            2'd1:    val = 4'h6;
            2'd2:    val = 4'h3;
            default: val = 4'h0;
        endcase
        return val;
    endfunction

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = 2'd0;
        priority casez (req)
            4'b???1: winner = 2'd0;
            4'b??10: winner = 2'd1;
            4'b?100: winner = 2'd2;
            4'b1000: winner = 2'd3;
            default: winner = 2'd0;
        endcase
    end
`else
    logic [1:0] ptr_q;
    logic [1:0] rr_idx;

    // Walk the offsets from farthest to nearest, so the nearest active
    // requester at or above ptr is the one that sticks.
    always_comb begin
        winner = ptr_q;
        rr_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = ptr_q + 2'(k);
            if (req[rr_idx]) begin
                winner = rr_idx;
            end
        end
    end
`endif

    assign winner_sel = sel[{winner, 1'b0} +: 2];
    assign held_sel   = sel[{win_q, 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= 2'd0;
            win_q      <= 2'd0;
            gnt        <= 4'b0000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 2'd0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_q      <= 2'(PTR_INIT);
`endif
        end else begin
            // The set in StGrant is written later in this block, so a same-cycle set wins.
            if (err_clr) begin
                err_sticky <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        gnt     <= 4'b0001 << winner;
                        sel_q   <= winner_sel;
                        win_q   <= winner;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    rsp_data  <= DATA_W'(lookup(sel_q));
                    rsp_err   <= (sel_q == 2'd3);
                    rsp_id    <= win_q;
                    rsp_valid <= 1'b1;
                    if (sel_q == 2'd3) begin
                        err_sticky <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (lock[win_q] && req[win_q]) begin
                        sel_q   <= held_sel;
                        state_q <= StGrant;
                    end else begin
                        gnt     <= 4'b0000;
`ifndef ARB_FIXED_PRIORITY_EN
                        ptr_q   <= win_q + 2'd1;
`endif
                        state_q <= StIdle;
                    end
                end
                default: begin
                    gnt       <= 4'b0000;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_lookup_arbiter.sv
// Self-checking bench for case_lookup_arbiter (DATA_W=4, PTR_INIT=0).
// Expected responses are queued when stimulus is applied. A negedge monitor
// pops and compares them whenever rsp_valid is seen.
module tb_case_lookup_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] sel = 8'h00;
    logic [3:0] lock = 4'b0000;
    logic       err_clr = 1'b0;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       err_sticky;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    case_lookup_arbiter #(
        .DATA_W  (4),
        .PTR_INIT(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .lock      (lock),
        .err_clr   (err_clr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference lookup table.
    function automatic logic [3:0] ref_data(input logic [1:0] code);
        case (code)
            2'd0:    return 4'hA;
            2'd1:    return 4'h6;
            2'd2:    return 4'h3;
            default: return 4'h0;
        endcase
    endfunction

    function automatic rsp_t mk(input logic [1:0] id, input logic [1:0] code);
        rsp_t r;
        r.id   = id;
        r.data = ref_data(code);
        r.err  = (code == 2'd3);
        return r;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic apply_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        lock    = 4'b0000;
        err_clr = 1'b0;
        sel     = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ids [5];
        logic [1:0] ids2 [4];

        // Reset state, then idle with no requests.
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'd0);
        end

        // Single request; the request drops during GRANT and is still served.
        req = 4'b0010;
        sel = 8'b0000_1000;
        exp_q.push_back(mk(2'd1, 2'd2));
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        @(negedge clk);
        check("single_gnt_resp", 32'(gnt), 32'b0010);
        check("single_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("single_gnt_off", 32'(gnt), 32'd0);
        check("single_valid_off", 32'(rsp_valid), 32'd0);
        @(negedge clk);

        // All four requesting, no lock.
        apply_reset();
        @(negedge clk);
`ifdef ARB_FIXED_PRIORITY_EN
        ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        sel = 8'b00_10_01_00;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk(ids[k], sel[2*ids[k] +: 2]));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << ids[k]));
            @(negedge clk);
            @(negedge clk);
        end
        req = 4'b0000;
        @(negedge clk);

        // Locked burst on requester 2 with a stepping select, then release.
        apply_reset();
        @(negedge clk);
        req  = 4'b0100;
        lock = 4'b0100;
        sel  = 8'b00_00_00_00;
        exp_q.push_back(mk(2'd2, 2'd0));
        exp_q.push_back(mk(2'd2, 2'd1));
        exp_q.push_back(mk(2'd2, 2'd2));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("lock_gnt", 32'(gnt), 32'b0100);
            check("lock_valid", 32'(rsp_valid), 32'(c % 2 == 0));
            if (c == 2) sel[5:4] = 2'd1;
            if (c == 4) sel[5:4] = 2'd2;
        end
        lock = 4'b0000;
        req  = 4'b1100;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_q.push_back(mk(2'd2, 2'd2));
`else
        exp_q.push_back(mk(2'd3, 2'd0));
`endif
        @(negedge clk);
        check("lock_release", 32'(gnt), 32'd0);
        @(negedge clk);
`ifdef ARB_FIXED_PRIORITY_EN
        check("after_lock_gnt", 32'(gnt), 32'b0100);
`else
        check("after_lock_gnt", 32'(gnt), 32'b1000);
`endif
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Uncovered select: error flag, sticky behaviour, clear priority.
        apply_reset();
        @(negedge clk);
        req  = 4'b0001;
        lock = 4'b0001;
        sel  = 8'b0000_0011;
        exp_q.push_back(mk(2'd0, 2'd3));
        exp_q.push_back(mk(2'd0, 2'd3));
        @(negedge clk);
        check("err_sticky_pre", 32'(err_sticky), 32'd0);
        @(negedge clk);
        check("err_sticky_set", 32'(err_sticky), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        lock    = 4'b0000;
        req     = 4'b0000;
        @(negedge clk);
        check("err_set_wins", 32'(err_sticky), 32'd1);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_held", 32'(err_sticky), 32'd1);
        check("err_rsp_err_off", 32'(rsp_err), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        check("err_cleared", 32'(err_sticky), 32'd0);
        err_clr = 1'b0;

        // Reset mid-GRANT: outputs drop immediately and no response follows.
        apply_reset();
        @(negedge clk);
        req = 4'b0001;
        sel = 8'h00;
        @(negedge clk);
        check("midrst_gnt_pre", 32'(gnt), 32'b0001);
        #1 rst_n = 1'b0;
        req = 4'b0000;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Requesters 1 and 3 held together.
        apply_reset();
        @(negedge clk);
`ifdef ARB_FIXED_PRIORITY_EN
        ids2 = '{2'd1, 2'd1, 2'd1, 2'd1};
`else
        ids2 = '{2'd1, 2'd3, 2'd1, 2'd3};
`endif
        sel = 8'b10_00_01_00;
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(ids2[k], sel[2*ids2[k] +: 2]));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pair_gnt", 32'(gnt), 32'(4'b0001 << ids2[k]));
            @(negedge clk);
            @(negedge clk);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        check("rsp_missing", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
